// File: rtl/comb_equalizer_if.sv
// Sample-strobed I/Q bus between the comb equalizer and its neighbours.
// slave is the equalizer side, master the source/sink side.
interface comb_equalizer_if #(
    parameter int BIT_WIDTH = 16
);
    logic                        strobe_in;
    logic signed [BIT_WIDTH-1:0] i_in;
    logic signed [BIT_WIDTH-1:0] q_in;
    logic                        strobe_out;
    logic signed [BIT_WIDTH-1:0] i_out;
    logic signed [BIT_WIDTH-1:0] q_out;
    logic                        overflow;

    modport master (
        output strobe_in, i_in, q_in,
        input  strobe_out, i_out, q_out, overflow
    );

    modport slave (
        input  strobe_in, i_in, q_in,
        output strobe_out, i_out, q_out, overflow
    );
endinterface

// File: rtl/comb_equalizer.sv
// Feed-forward inverse of the receive comb resonator on I and Q:
// x = y + y[n-D] - (y[n-D] >>> FB_SHIFT), saturated, with clip flag.
module comb_equalizer #(
    parameter int BIT_WIDTH  = 16,
    parameter int DELAY_LOG2 = 3,
    parameter int FB_SHIFT   = 3
) (
    input  logic             clock,
    input  logic             reset,
    comb_equalizer_if.slave  bus
);
    localparam int D  = 1 << DELAY_LOG2;
    localparam int W2 = BIT_WIDTH + 2;

    localparam logic signed [W2-1:0] SMAX =
        {3'b000, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [W2-1:0] SMIN =
        {3'b111, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [DELAY_LOG2:0] FILL_LAST =
        (DELAY_LOG2+1)'(D - 1);

    typedef enum logic {PRIME, RUN} state_t;

    state_t                      r_state;
    logic [DELAY_LOG2-1:0]       r_wr_ptr;
    logic [DELAY_LOG2:0]         r_fill_cnt;
    logic signed [BIT_WIDTH-1:0] r_ram_i [D];
    logic signed [BIT_WIDTH-1:0] r_ram_q [D];
    logic signed [BIT_WIDTH-1:0] r_i_out;
    logic signed [BIT_WIDTH-1:0] r_q_out;
    logic                        r_strobe_out;
    logic                        r_overflow;

    logic signed [BIT_WIDTH-1:0] w_i_d;
    logic signed [BIT_WIDTH-1:0] w_q_d;
    logic [BIT_WIDTH:0]          w_i_res;
    logic [BIT_WIDTH:0]          w_q_res;

    function automatic logic [BIT_WIDTH:0] eq_sat(
        input logic signed [BIT_WIDTH-1:0] x,
        input logic signed [BIT_WIDTH-1:0] d
    );
        logic signed [W2-1:0] xe;
        logic signed [W2-1:0] de;
        logic signed [W2-1:0] s;
        xe = {{2{x[BIT_WIDTH-1]}}, x};
        de = {{2{d[BIT_WIDTH-1]}}, d};
        s  = xe + de - (de >>> FB_SHIFT);
        if (s > SMAX)
            return {1'b1, SMAX[BIT_WIDTH-1:0]};
        else if (s < SMIN)
            return {1'b1, SMIN[BIT_WIDTH-1:0]};
        else
            return {1'b0, s[BIT_WIDTH-1:0]};
    endfunction

    // History is masked until the delay line has been refilled since reset.
    assign w_i_d = (r_state == RUN) ? r_ram_i[r_wr_ptr] : '0;
    assign w_q_d = (r_state == RUN) ? r_ram_q[r_wr_ptr] : '0;

    assign w_i_res = eq_sat(bus.i_in, w_i_d);
    assign w_q_res = eq_sat(bus.q_in, w_q_d);

    always_ff @(posedge clock) begin
        if (bus.strobe_in && !reset) begin
            r_ram_i[r_wr_ptr] <= bus.i_in;
            r_ram_q[r_wr_ptr] <= bus.q_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= PRIME;
            r_wr_ptr     <= '0;
            r_fill_cnt   <= '0;
            r_i_out      <= '0;
            r_q_out      <= '0;
            r_strobe_out <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_strobe_out <= bus.strobe_in;
            r_overflow   <= 1'b0;
            if (bus.strobe_in) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_i_out    <= w_i_res[BIT_WIDTH-1:0];
                r_q_out    <= w_q_res[BIT_WIDTH-1:0];
                r_overflow <= w_i_res[BIT_WIDTH] | w_q_res[BIT_WIDTH];
                unique case (r_state)
                    PRIME: begin
                        r_fill_cnt <= r_fill_cnt + 1'b1;
                        if (r_fill_cnt == FILL_LAST)
                            r_state <= RUN;
                    end
                    RUN: r_state <= RUN;
                    default: r_state <= PRIME;
                endcase
            end
        end
    end

    assign bus.strobe_out = r_strobe_out;
    assign bus.i_out      = r_i_out;
    assign bus.q_out      = r_q_out;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_comb_equalizer.sv
// Directed bench for comb_equalizer: impulse, round trip, saturation,
// strobe gaps and asynchronous reset mid-stream.
module tb_comb_equalizer;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    comb_equalizer_if #(.BIT_WIDTH(16)) bus ();

    comb_equalizer #(
        .BIT_WIDTH (16),
        .DELAY_LOG2(3),
        .FB_SHIFT  (3)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " i0"}, int'(bus.i_out), 0);
        check({tag, " q0"}, int'(bus.q_out), 0);
        check({tag, " stb0"}, int'(bus.strobe_out), 0);
        check({tag, " ov0"}, int'(bus.overflow), 0);
    endtask

    // One accepted sample, then gap idle cycles with outputs held.
    task automatic push(input string tag, input int i, input int q,
                        input int ei, input int eq, input int eov,
                        input int gap);
        bus.strobe_in = 1'b1;
        bus.i_in      = 16'(i);
        bus.q_in      = 16'(q);
        @(negedge clk);
        check({tag, " stb"}, int'(bus.strobe_out), 1);
        check({tag, " i"}, int'(bus.i_out), ei);
        check({tag, " q"}, int'(bus.q_out), eq);
        check({tag, " ov"}, int'(bus.overflow), eov);
        bus.strobe_in = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check({tag, " gap stb"}, int'(bus.strobe_out), 0);
            check({tag, " gap ov"}, int'(bus.overflow), 0);
            check({tag, " gap i"}, int'(bus.i_out), ei);
        end
    endtask

    // Strobes presented during reset must be ignored.
    task automatic do_reset(input string tag);
        rst           = 1'b1;
        bus.strobe_in = 1'b1;
        bus.i_in      = 16'sd1234;
        bus.q_in      = -16'sd1234;
        #1;
        check_idle({tag, " async"});
        @(negedge clk);
        @(negedge clk);
        check_idle({tag, " held"});
        bus.strobe_in = 1'b0;
        rst           = 1'b0;
    endtask

    task automatic impulse(input string tag, input int gap);
        int ei;
        for (int k = 0; k < 16; k++) begin
            ei = (k == 0) ? 1000 : (k == 8) ? 875 : 0;
            push(tag, (k == 0) ? 1000 : 0, 0, ei, 0, 0, gap);
        end
    endtask

    int unsigned seed;
    int yi_h [8];
    int yq_h [8];
    int xi, xq, yi, yq, di, dq;

    initial begin
        bus.strobe_in = 1'b0;
        bus.i_in      = '0;
        bus.q_in      = '0;
        rst           = 1'b0;
        @(negedge clk);
        do_reset("rst0");

        impulse("imp", 0);

        do_reset("rst1");
        for (int k = 0; k < 16; k++)
            push("sat", 32767, -32768,
                 32767, -32768, (k >= 8) ? 1 : 0, 0);

        do_reset("rst2");
        impulse("gap", 2);

        // Fill with 5000s, then reset asynchronously between edges.
        do_reset("rst3");
        for (int k = 0; k < 10; k++)
            push("fill", 5000, -5000,
                 (k < 8) ? 5000 : 9375,
                 (k < 8) ? -5000 : -9375, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle("mid async");
        @(negedge clk);
        check_idle("mid held");
        rst = 1'b0;
        impulse("imp2", 0);

        // Upstream comb model; +-4000 keeps its state inside 16 bits.
        do_reset("rst4");
        seed = 32'h1234_5678;
        for (int k = 0; k < 8; k++) begin
            yi_h[k] = 0;
            yq_h[k] = 0;
        end
        for (int n = 0; n < 32; n++) begin
            seed = seed * 32'd1103515245 + 32'd12345;
            xi   = int'((seed >> 8) % 32'd8001) - 4000;
            seed = seed * 32'd1103515245 + 32'd12345;
            xq   = int'((seed >> 8) % 32'd8001) - 4000;
            di   = yi_h[n % 8];
            dq   = yq_h[n % 8];
            yi   = xi - di + (di >>> 3);
            yq   = xq - dq + (dq >>> 3);
            yi_h[n % 8] = yi;
            yq_h[n % 8] = yq;
            push("rt", yi, yq, xi, xq, 0, n % 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
